// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM and its ALUOp decoder.
// Optional TRAP state is compiled in only when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int ALUOP_WIDTH  = 4;
  localparam int STATE_WIDTH  = 4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    R_EXEC   = 4'd7,
    R_WB     = 4'd8,
    I_EXEC   = 4'd9,
    I_WB     = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12
`ifdef CTRL_ILLEGAL_TRAP_EN
    , TRAP   = 4'd13
`endif
  } stateT;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWriteCond;
    logic       pcWrite;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       irWrite;
    logic [1:0] pcSource;
    logic [3:0] aluOp;
    logic [1:0] aluSrcB;
    logic       aluSrcA;
    logic       regWrite;
    logic       regDst;
  } ctrlT;

  // Moore decode of one state; execOp supplies the funct/opcode-derived ALUOp for EXEC states.
  function automatic ctrlT decodeState(stateT s, logic [3:0] execOp);
    ctrlT c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead  = 1'b1;
        c.irWrite  = 1'b1;
        c.pcWrite  = 1'b1;
        c.aluSrcB  = SRCB_ONE;
        c.aluOp    = ALU_ADD;
        c.pcSource = PCSRC_ALU;
      end
      DECODE: begin
        c.aluSrcB = SRCB_SHIMM;
        c.aluOp   = ALU_ADD;
      end
      MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_ADD;
      end
      MEM_RD: c.memRead = 1'b1;
      MEM_WB: begin
        c.regWrite = 1'b1;
        c.memtoReg = 1'b1;
      end
      MEM_WR: c.memWrite = 1'b1;
      R_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_B;
        c.aluOp   = execOp;
      end
      R_WB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      I_EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = execOp;
      end
      I_WB: c.regWrite = 1'b1;
      BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluSrcB     = SRCB_B;
        c.aluOp       = ALU_SUB;
        c.pcWriteCond = 1'b1;
        c.pcSource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = PCSRC_JUMP;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp selection: funct map for R-type, opcode map for immediates.
module alu_op_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] funct,
  output logic [ALUOP_W-1:0]  aluOp
);

  always_comb begin
    aluOp = ALU_ADD;
    if (opcode == OP_R) begin
      case (funct)
        FN_SUB:  aluOp = ALU_SUB;
        FN_AND:  aluOp = ALU_AND;
        FN_OR:   aluOp = ALU_OR;
        FN_SLT:  aluOp = ALU_SLT;
        default: aluOp = ALU_ADD;
      endcase
    end else begin
      case (opcode)
        OP_ANDI: aluOp = ALU_AND;
        OP_ORI:  aluOp = ALU_OR;
        default: aluOp = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle datapath; outputs are registered from the next-state decode.
// Define CTRL_ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state instead of a NOP.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [OPCODE_W-1:0] funct,
  input  logic                mem_ready,
  output logic                PCWriteCond,
  output logic                PCWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          ALUSrcB,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                instr_done,
  output logic [STATE_W-1:0]  state
);

  stateT              curState, nextState;
  ctrlT               ctrlQ, ctrlD;
  logic               instrDoneQ, instrDoneD;
  logic [ALUOP_W-1:0] execAluOp;

  alu_op_decode #(
    .OPCODE_W(OPCODE_W),
    .ALUOP_W (ALUOP_W)
  ) uAluOpDecode (
    .opcode(opcode),
    .funct (funct),
    .aluOp (execAluOp)
  );

  always_comb begin
    nextState = curState;
    case (curState)
      IDLE:     nextState = FETCH;
      FETCH:    if (mem_ready) nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:                     nextState = R_EXEC;
          OP_LW, OP_SW:             nextState = MEM_ADDR;
          OP_BEQ:                   nextState = BRANCH;
          OP_J:                     nextState = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: nextState = I_EXEC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                  nextState = TRAP;
`else
          default:                  nextState = FETCH;
`endif
        endcase
      end
      MEM_ADDR: nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) nextState = MEM_WB;
      MEM_WR:   if (mem_ready) nextState = FETCH;
      R_EXEC:   nextState = R_WB;
      I_EXEC:   nextState = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP: nextState = FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP:     nextState = TRAP;
`endif
      default:  nextState = IDLE;
    endcase

    ctrlD = decodeState(nextState, execAluOp);
    // Retire only on a real entry into FETCH, not the first fetch or a stalled hold.
    instrDoneD = (nextState == FETCH) && (curState != IDLE) && (curState != FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curState   <= IDLE;
      ctrlQ      <= '0;
      instrDoneQ <= 1'b0;
    end else begin
      curState   <= nextState;
      ctrlQ      <= ctrlD;
      instrDoneQ <= instrDoneD;
    end
  end

  // FETCH must not advance PC or load IR until memory actually returns the word.
  assign PCWrite     = ctrlQ.pcWrite & ((curState != FETCH) | mem_ready);
  assign IRWrite     = ctrlQ.irWrite & ((curState != FETCH) | mem_ready);
  assign PCWriteCond = ctrlQ.pcWriteCond;
  assign MemRead     = ctrlQ.memRead;
  assign MemWrite    = ctrlQ.memWrite;
  assign MemtoReg    = ctrlQ.memtoReg;
  assign PCSource    = ctrlQ.pcSource;
  assign ALUOp       = ctrlQ.aluOp;
  assign ALUSrcB     = ctrlQ.aluSrcB;
  assign ALUSrcA     = ctrlQ.aluSrcA;
  assign RegWrite    = ctrlQ.regWrite;
  assign RegDst      = ctrlQ.regDst;
  assign instr_done  = instrDoneQ;
  assign state       = STATE_W'(curState);

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore control FSM that sequences the multicycle Datapath. It drives every Datapath control input from the opcode and funct fields of the instruction register. It stalls on a memory-ready handshake and pulses a retire strobe once per completed instruction. It sits beside Datapath in the CPU top level and replaces stimulus-driven control.

Parameters:
OPCODE_W, 6, opcode and funct field width
ALUOP_W, 4, ALUOp width
STATE_W, 4, state register width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  IR[31:26], stable from the cycle after FETCH completes
funct  in  OPCODE_W  IR[5:0]
mem_ready  in  1  memory completes the access this cycle
PCWriteCond  out  1  conditional PC write (Datapath ANDs with zero)
PCWrite  out  1  unconditional PC write
MemRead  out  1
MemWrite  out  1
MemtoReg  out  1
IRWrite  out  1
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
ALUOp  out  ALUOP_W  ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111
ALUSrcB  out  2  00 B, 01 const 1, 10 sign-ext imm, 11 shifted imm
ALUSrcA  out  1  0 PC, 1 A
RegWrite  out  1
RegDst  out  1  0 rt, 1 rd
instr_done  out  1  one-cycle retire pulse
state  out  STATE_W  debug view of the state register

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset: state=IDLE, all outputs 0.
- Outputs are registered. They are loaded with the decode of next_state, so they match state in the same cycle.
- Exception: PCWrite and IRWrite in FETCH are the registered value ANDed with mem_ready (combinational gate).
- States and codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, I_EXEC 9, I_WB 10, BRANCH 11, JUMP 12, TRAP 13.
- Per-state outputs; any unlisted output is 0:
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ADD.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ADD.
  - MEM_RD: MemRead.
  - MEM_WB: RegWrite, MemtoReg, RegDst=0.
  - MEM_WR: MemWrite.
  - R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=funct map.
  - R_WB: RegWrite, RegDst=1.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=opcode map.
  - I_WB: RegWrite, RegDst=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSource=01.
  - JUMP: PCWrite, PCSource=10.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, ANDI 001100, ORI 001101.
- Funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, anything else ADD.
- Transitions:
  - IDLE to FETCH.
  - FETCH to DECODE when mem_ready, else hold.
  - DECODE: R to R_EXEC; LW/SW to MEM_ADDR; BEQ to BRANCH; J to JUMP; ADDI/ANDI/ORI to I_EXEC; unknown opcode to FETCH (treated as NOP).
  - MEM_ADDR to MEM_RD for LW, else MEM_WR.
  - MEM_RD to MEM_WB when mem_ready, else hold.
  - MEM_WR to FETCH when mem_ready, else hold. MemWrite stays high while holding.
  - R_EXEC to R_WB; I_EXEC to I_WB.
  - MEM_WB, R_WB, I_WB, BRANCH, JUMP to FETCH.
- instr_done: registered. It is 1 for exactly the cycle in which FETCH is entered from any state except IDLE. It is 0 after reset and never asserted from TRAP.
- Reset mid-instruction, including a memory stall: the next edge forces IDLE with all outputs 0. No partial write-enable survives past that edge.
- CPI: LW 5, SW 4, R/I 4, BEQ/J 3, plus one cycle per stalled memory cycle.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all write-enables at 0 and stays until reset. The state port reads 13.
- Undefined: an unknown opcode returns to FETCH as a NOP and instr_done pulses. The TRAP state is not compiled in.

Decomposition:
- Package ctrl_pkg: state encodings, opcode constants, funct constants, ALUOp codes, ALUSrcB and PCSource select constants.
- Sub-module alu_op_decode: combinational mapping from opcode and funct to ALUOp, instantiated once.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1 -> outputs all 0 during reset; state 0 then 1; FETCH shows PCWrite=1, IRWrite=1, ALUSrcB=01, ALUOp=0010.
- LW (100011) with mem_ready low for 2 cycles in FETCH and 1 in MEM_RD -> states 1,1,1,2,3,4,4,5,1; MEM_WB shows RegWrite=1, MemtoReg=1; instr_done pulses once on re-entry to FETCH.
- R-type with funct 100010, then funct 101010 -> R_EXEC ALUOp=0110 and then 0111; R_WB shows RegWrite=1, RegDst=1; 4 cycles per instruction.
- BEQ (000100) then J (000010) -> BRANCH shows PCWriteCond=1, PCSource=01, ALUOp=0110; JUMP shows PCWrite=1, PCSource=10; 3 cycles each.
- Opcode 111111 -> macro undefined: FETCH next cycle and instr_done=1. Macro defined: state=13, all write-enables 0, held until reset.
- Reset asserted in MEM_WR with mem_ready=0 -> MemWrite=0 and state=0 after the edge; normal fetch resumes after release.
